// File: rtl/heartbeat_monitor.sv
// Heartbeat receiver: measures beat-to-beat period, declares lock, flags early/missing beats.
// Optional last-period capture register enabled by defining HEARTBEAT_PERIOD_CAPTURE_EN.
module heartbeat_monitor #(
  parameter int EXPECTED_COUNTS = 50_000_000,
  parameter int TOLERANCE       = 0,
  parameter int LOCK_BEATS      = 4
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          enable,
  input  logic                                          beat,
  output logic                                          locked,
  output logic                                          fault_early,
  output logic                                          fault_missing,
  output logic [7:0]                                    fault_count,
  output logic [$clog2(EXPECTED_COUNTS+TOLERANCE+2)-1:0] last_period,
  output logic [1:0]                                    dbg_state
);

  localparam int TMO = EXPECTED_COUNTS + TOLERANCE + 1;
  localparam int CW  = $clog2(TMO + 1);
  localparam logic [CW-1:0] TMO_C     = CW'(TMO);
  localparam logic [CW-1:0] WIN_LO    = CW'(EXPECTED_COUNTS - TOLERANCE);
  localparam logic [7:0]    LOCK_LAST = 8'(LOCK_BEATS - 1);

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED, FAULT} state_t;

  state_t          state;
  logic [CW-1:0]   period_cnt;
  logic [7:0]      good_cnt;
  logic            tracking;
  logic            timeout;
  logic            accept;
  logic            early;

  // A beat is only judged while tracking; a timeout in the same cycle overrides it.
  always_comb begin
    tracking = (state == ACQUIRE) || (state == LOCKED);
    timeout  = tracking && (period_cnt == TMO_C);
    accept   = tracking && beat && !timeout;
    early    = accept && (period_cnt < WIN_LO);
  end

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      period_cnt    <= '0;
      good_cnt      <= '0;
      locked        <= 1'b0;
      fault_early   <= 1'b0;
      fault_missing <= 1'b0;
      fault_count   <= '0;
    end else if (!enable) begin
      state         <= IDLE;
      period_cnt    <= '0;
      good_cnt      <= '0;
      locked        <= 1'b0;
      fault_early   <= 1'b0;
      fault_missing <= 1'b0;
    end else begin
      fault_early   <= early;
      fault_missing <= timeout;
      if ((early || timeout) && (fault_count != 8'hFF))
        fault_count <= fault_count + 8'd1;
      case (state)
        IDLE, FAULT: begin
          if (beat) begin
            state      <= ACQUIRE;
            period_cnt <= CW'(1);
            good_cnt   <= '0;
          end
        end
        ACQUIRE, LOCKED: begin
          if (timeout) begin
            state  <= FAULT;
            locked <= 1'b0;
          end else if (accept) begin
            period_cnt <= CW'(1);
            if (early) begin
              state    <= ACQUIRE;
              good_cnt <= '0;
              locked   <= 1'b0;
            end else if (state == ACQUIRE) begin
              good_cnt <= good_cnt + 8'd1;
              if (good_cnt == LOCK_LAST) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end
          end else begin
            period_cnt <= period_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HEARTBEAT_PERIOD_CAPTURE_EN
  always_ff @(posedge clk) begin
    if (reset || !enable)
      last_period <= '0;
    else if (accept)
      last_period <= period_cnt;
  end
`else
  assign last_period = '0;
`endif

endmodule

// File: tb/tb_heartbeat_monitor.sv
// Directed bench for heartbeat_monitor with EXPECTED_COUNTS=10, TOLERANCE=1, LOCK_BEATS=3.
module tb_heartbeat_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       beat;
  logic       locked;
  logic       fault_early;
  logic       fault_missing;
  logic [7:0] fault_count;
  logic [3:0] last_period;
  logic [1:0] dbg_state;

  int tests = 0;
  int failed = 0;
  int exp_count;

  heartbeat_monitor #(
    .EXPECTED_COUNTS(10),
    .TOLERANCE(1),
    .LOCK_BEATS(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .beat(beat),
    .locked(locked),
    .fault_early(fault_early),
    .fault_missing(fault_missing),
    .fault_count(fault_count),
    .last_period(last_period),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   gap;
    logic locked;
    logic early;
    int   count;
    int   last;
  } vec_t;

  vec_t vecs[16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pulses beat so that it is sampled exactly gap edges after the previous beat edge.
  task automatic beat_after(input int gap);
    beat = 1'b0;
    repeat (gap - 1) tick();
    beat = 1'b1;
    tick();
    beat = 1'b0;
  endtask

  function automatic int exp_last(input int v);
`ifdef HEARTBEAT_PERIOD_CAPTURE_EN
    return v;
`else
    return 0;
`endif
  endfunction

  initial begin
    vecs[0]  = '{3,  1'b0, 1'b0, 0, 0};
    vecs[1]  = '{10, 1'b0, 1'b0, 0, 10};
    vecs[2]  = '{10, 1'b0, 1'b0, 0, 10};
    vecs[3]  = '{10, 1'b1, 1'b0, 0, 10};
    vecs[4]  = '{9,  1'b1, 1'b0, 0, 9};
    vecs[5]  = '{11, 1'b1, 1'b0, 0, 11};
    vecs[6]  = '{10, 1'b1, 1'b0, 0, 10};
    vecs[7]  = '{8,  1'b0, 1'b1, 1, 8};
    vecs[8]  = '{10, 1'b0, 1'b0, 1, 10};
    vecs[9]  = '{10, 1'b0, 1'b0, 1, 10};
    vecs[10] = '{10, 1'b1, 1'b0, 1, 10};
    vecs[11] = '{9,  1'b1, 1'b0, 1, 9};
    vecs[12] = '{11, 1'b1, 1'b0, 1, 11};
    vecs[13] = '{8,  1'b0, 1'b1, 2, 8};
    vecs[14] = '{4,  1'b0, 1'b1, 3, 4};
    vecs[15] = '{1,  1'b0, 1'b1, 4, 1};

    reset = 1'b1;
    enable = 1'b1;
    beat = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    chk("reset_locked", locked, 0);
    chk("reset_early", fault_early, 0);
    chk("reset_missing", fault_missing, 0);
    chk("reset_count", fault_count, 0);
    chk("reset_last", last_period, 0);
    chk("reset_state", dbg_state, 0);

    // Lock, jitter inside the window, early faults in LOCKED and ACQUIRE.
    for (int i = 0; i < 16; i++) begin
      beat_after(vecs[i].gap);
      chk($sformatf("vec%0d_locked", i), locked, vecs[i].locked);
      chk($sformatf("vec%0d_early", i), fault_early, vecs[i].early);
      chk($sformatf("vec%0d_missing", i), fault_missing, 0);
      chk($sformatf("vec%0d_count", i), fault_count, vecs[i].count);
      chk($sformatf("vec%0d_last", i), last_period, exp_last(vecs[i].last));
    end
    tick();
    chk("early_one_cycle", fault_early, 0);

    // Missing beat after lock.
    for (int i = 0; i < 3; i++) beat_after(10);
    chk("relock_pre_tmo", locked, 1);
    for (int j = 1; j <= 14; j++) begin
      tick();
      chk($sformatf("tmo_missing_%0d", j), fault_missing, (j == 12));
      chk($sformatf("tmo_locked_%0d", j), locked, (j < 12));
      chk($sformatf("tmo_count_%0d", j), fault_count, (j >= 12) ? 5 : 4);
    end
    chk("tmo_state_fault", dbg_state, 3);
    beat_after(5);
    chk("fault_ref_early", fault_early, 0);
    chk("fault_ref_missing", fault_missing, 0);
    chk("fault_ref_count", fault_count, 5);
    chk("fault_ref_state", dbg_state, 1);
    for (int i = 0; i < 3; i++) begin
      beat_after(10);
      chk($sformatf("relock_after_fault_%0d", i), locked, (i == 2));
    end

    // Beat coincident with timeout: timeout wins, beat ignored.
    beat_after(12);
    chk("coinc_missing", fault_missing, 1);
    chk("coinc_early", fault_early, 0);
    chk("coinc_locked", locked, 0);
    chk("coinc_count", fault_count, 6);
    chk("coinc_state", dbg_state, 3);
    beat_after(10);
    chk("coinc_ref_early", fault_early, 0);
    chk("coinc_ref_locked", locked, 0);
    chk("coinc_ref_count", fault_count, 6);
    for (int i = 0; i < 3; i++) begin
      beat_after(10);
      chk($sformatf("coinc_relock_%0d", i), locked, (i == 2));
    end

    // Reset mid-period while locked.
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_locked", locked, 0);
    chk("midrst_early", fault_early, 0);
    chk("midrst_missing", fault_missing, 0);
    chk("midrst_count", fault_count, 0);
    chk("midrst_last", last_period, 0);
    chk("midrst_state", dbg_state, 0);
    beat_after(6);
    chk("midrst_ref_locked", locked, 0);
    chk("midrst_ref_last", last_period, 0);
    for (int i = 0; i < 3; i++) begin
      beat_after(10);
      chk($sformatf("midrst_relock_%0d", i), locked, (i == 2));
    end

    // enable low with beats present.
    beat_after(5);
    chk("pre_dis_early", fault_early, 1);
    chk("pre_dis_count", fault_count, 1);
    enable = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      beat = (c % 7 == 0);
      tick();
      chk($sformatf("dis_locked_%0d", c), locked, 0);
      chk($sformatf("dis_faults_%0d", c), {fault_early, fault_missing}, 0);
      chk($sformatf("dis_count_%0d", c), fault_count, 1);
      chk($sformatf("dis_state_%0d", c), dbg_state, 0);
    end
    beat = 1'b0;
    enable = 1'b1;
    beat_after(3);
    chk("reen_ref_locked", locked, 0);
    chk("reen_ref_state", dbg_state, 1);
    for (int i = 0; i < 3; i++) begin
      beat_after(10);
      chk($sformatf("reen_lock_%0d", i), locked, (i == 2));
      chk($sformatf("reen_count_%0d", i), fault_count, 1);
    end

    // Repeated timeouts drive fault_count into saturation.
    exp_count = 1;
    for (int i = 0; i < 300; i++) begin
      beat_after(20);
      exp_count = (exp_count < 255) ? exp_count + 1 : 255;
      chk($sformatf("sat_count_%0d", i), fault_count, exp_count);
    end
    for (int j = 1; j <= 12; j++) tick();
    chk("sat_missing_pulse", fault_missing, 1);
    tick();
    chk("sat_final_count", fault_count, 255);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
